// File: rtl/demux_1_to_3_32_bit_pkg.sv
`default_nettype none
// ============================================================================
// demux_1_to_3_32_bit_pkg : shared word constants and channel encodings
// Revision: 1.0
// ============================================================================
package demux_1_to_3_32_bit_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_OUT = 3;

  localparam logic [DATA_W-1:0] WORD_ZERO = '0;

  // Shared with the 3-to-1 mux so both blocks decode channels identically.
  localparam logic [1:0] OUT_0   = 2'b00;
  localparam logic [1:0] OUT_1   = 2'b01;
  localparam logic [1:0] OUT_2   = 2'b10;
  localparam logic [1:0] DISCARD = 2'b11;

  typedef logic [1:0] chan_sel_t;

  function automatic chan_sel_t chan_code(input int idx);
    chan_sel_t code;
    case (idx)
      0:       code = OUT_0;
      1:       code = OUT_1;
      2:       code = OUT_2;
      default: code = DISCARD;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1_to_3_32_bit_if.sv
`default_nettype none
// ============================================================================
// demux_1_to_3_32_bit_if : producer and three consumer handshakes
// Revision: 1.0
// ============================================================================
interface demux_1_to_3_32_bit_if #(
  parameter int WIDTH      = 32,
  parameter int DROP_CNT_W = 8
);

  logic [WIDTH-1:0]      in_data;
  logic [1:0]            in_sel;
  logic                  in_valid;
  logic                  in_ready;

  logic [WIDTH-1:0]      out_0_data;
  logic                  out_0_valid;
  logic                  out_0_ready;
  logic [WIDTH-1:0]      out_1_data;
  logic                  out_1_valid;
  logic                  out_1_ready;
  logic [WIDTH-1:0]      out_2_data;
  logic                  out_2_valid;
  logic                  out_2_ready;

  logic [DROP_CNT_W-1:0] drop_count;

  modport master (
    output in_data, in_sel, in_valid,
    input  in_ready,
    input  out_0_data, out_0_valid,
    output out_0_ready,
    input  out_1_data, out_1_valid,
    output out_1_ready,
    input  out_2_data, out_2_valid,
    output out_2_ready,
    input  drop_count
  );

  modport slave (
    input  in_data, in_sel, in_valid,
    output in_ready,
    output out_0_data, out_0_valid,
    input  out_0_ready,
    output out_1_data, out_1_valid,
    input  out_1_ready,
    output out_2_data, out_2_valid,
    input  out_2_ready,
    output drop_count
  );

endinterface
`default_nettype wire

// File: rtl/demux_1_to_3_32_bit_out_slot.sv
`default_nettype none
// ============================================================================
// demux_out_slot : one-entry valid/ready holding register for one channel
// Revision: 1.0
// ============================================================================
module demux_out_slot
  import demux_1_to_3_32_bit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A draining slot can accept a replacement word on the same edge.
  assign free = !valid_q || drain_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && drain_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= WIDTH'(WORD_ZERO);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule
`default_nettype wire

// File: rtl/demux_1_to_3_32_bit.sv
`default_nettype none
// ============================================================================
// demux_1_to_3_32_bit : registered 1-to-3 word demux with saturating drop count
// Revision: 1.0
// ============================================================================
module demux_1_to_3_32_bit
  import demux_1_to_3_32_bit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DROP_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  demux_1_to_3_32_bit_if.slave    bus
);

  logic [NUM_OUT-1:0]    sel_hit;
  logic [NUM_OUT-1:0]    slot_load;
  logic [NUM_OUT-1:0]    slot_valid;
  logic [NUM_OUT-1:0]    slot_free;
  logic [NUM_OUT-1:0]    slot_drain;
  logic [WIDTH-1:0]      slot_data [NUM_OUT];
  logic                  in_ready;
  logic                  drop_accept;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

  assign slot_drain = {bus.out_2_ready, bus.out_1_ready, bus.out_0_ready};

  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      sel_hit[i] = (bus.in_sel == chan_code(i));
    end
  end

  // in_ready looks only at the selected slot so other stalls never block it.
  always_comb begin
    in_ready = 1'b1;
    case (bus.in_sel)
      OUT_0:   in_ready = slot_free[0];
      OUT_1:   in_ready = slot_free[1];
      OUT_2:   in_ready = slot_free[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign slot_load   = sel_hit & slot_free & {NUM_OUT{bus.in_valid}};
  assign drop_accept = bus.in_valid && (bus.in_sel == DISCARD);

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop_accept && (drop_count_q != {DROP_CNT_W{1'b1}})) begin
      drop_count_d = drop_count_q + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    demux_out_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .load        (slot_load[g]),
      .load_data   (bus.in_data),
      .drain_ready (slot_drain[g]),
      .valid       (slot_valid[g]),
      .data        (slot_data[g]),
      .free        (slot_free[g])
    );
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_0_valid = slot_valid[0];
  assign bus.out_0_data  = slot_data[0];
  assign bus.out_1_valid = slot_valid[1];
  assign bus.out_1_data  = slot_data[1];
  assign bus.out_2_valid = slot_valid[2];
  assign bus.out_2_data  = slot_data[2];
  assign bus.drop_count  = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_1_to_3_32_bit.sv
`default_nettype none
// ============================================================================
// tb_demux_1_to_3_32_bit : directed self-checking bench for the 1-to-3 demux
// Revision: 1.0
// ============================================================================
module tb_demux_1_to_3_32_bit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  logic any_valid;

  demux_1_to_3_32_bit_if #(.WIDTH(32), .DROP_CNT_W(8)) bus ();

  demux_1_to_3_32_bit #(
    .WIDTH      (32),
    .DROP_CNT_W (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = d;
  endtask

  initial begin
    n_vec       = 0;
    n_miss      = 0;
    rst         = 1'b0;
    drive(1'b0, 2'b00, 32'h0);
    bus.out_0_ready = 1'b1;
    bus.out_1_ready = 1'b1;
    bus.out_2_ready = 1'b1;
    #2;
    check_vec("rst_valid",    {29'b0, bus.out_2_valid, bus.out_1_valid, bus.out_0_valid}, 32'h0);
    check_vec("rst_drop",     {24'b0, bus.drop_count}, 32'h0);
    check_vec("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    #1 rst = 1'b1;
    tick();

    // Basic route to channel 1
    drive(1'b1, 2'b01, 32'hCCCC_CCCC);
    #1 check_vec("route_in_ready", {31'b0, bus.in_ready}, 32'h1);
    tick();
    drive(1'b0, 2'b00, 32'h0);
    check_vec("route_v1",   {31'b0, bus.out_1_valid}, 32'h1);
    check_vec("route_d1",   bus.out_1_data, 32'hCCCC_CCCC);
    check_vec("route_v0v2", {30'b0, bus.out_2_valid, bus.out_0_valid}, 32'h0);
    tick();
    check_vec("route_drain", {31'b0, bus.out_1_valid}, 32'h0);

    // Independent stall on channel 2
    bus.out_2_ready = 1'b0;
    drive(1'b1, 2'b10, 32'hDDDD_DDDD);
    #1 check_vec("stall_rdy_first", {31'b0, bus.in_ready}, 32'h1);
    tick();
    check_vec("stall_d2", bus.out_2_data, 32'hDDDD_DDDD);
    drive(1'b1, 2'b10, 32'h1111_1111);
    #1 check_vec("stall_rdy_second", {31'b0, bus.in_ready}, 32'h0);
    tick();
    check_vec("stall_d2_held", bus.out_2_data, 32'hDDDD_DDDD);
    drive(1'b1, 2'b00, 32'h2222_2222);
    #1 check_vec("stall_rdy_ch0", {31'b0, bus.in_ready}, 32'h1);
    tick();
    check_vec("stall_v0", {31'b0, bus.out_0_valid}, 32'h1);
    check_vec("stall_d0", bus.out_0_data, 32'h2222_2222);
    check_vec("stall_d2_still", bus.out_2_data, 32'hDDDD_DDDD);
    bus.out_2_ready = 1'b1;
    drive(1'b1, 2'b10, 32'h1111_1111);
    #1 check_vec("stall_rdy_release", {31'b0, bus.in_ready}, 32'h1);
    tick();
    check_vec("stall_v2_new", {31'b0, bus.out_2_valid}, 32'h1);
    check_vec("stall_d2_new", bus.out_2_data, 32'h1111_1111);
    check_vec("stall_v0_drained", {31'b0, bus.out_0_valid}, 32'h0);
    drive(1'b0, 2'b00, 32'h0);
    tick();
    check_vec("stall_v2_drained", {31'b0, bus.out_2_valid}, 32'h0);

    // Back-to-back into channel 0
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 32'hA5A5_0000 + 32'(i));
      #1 check_vec("b2b_in_ready", {31'b0, bus.in_ready}, 32'h1);
      tick();
      check_vec("b2b_v0", {31'b0, bus.out_0_valid}, 32'h1);
      check_vec("b2b_d0", bus.out_0_data, 32'hA5A5_0000 + 32'(i));
    end
    drive(1'b0, 2'b00, 32'h0);
    tick();
    check_vec("b2b_drained", {31'b0, bus.out_0_valid}, 32'h0);

    // Discard path with counter saturation
    any_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'b11, 32'h5A5A_0000 + 32'(i));
      #1 check_vec("drop_in_ready", {31'b0, bus.in_ready}, 32'h1);
      tick();
      any_valid = any_valid | bus.out_0_valid | bus.out_1_valid | bus.out_2_valid;
      if (i == 0)   check_vec("drop_cnt_1",   {24'b0, bus.drop_count}, 32'd1);
      if (i == 253) check_vec("drop_cnt_254", {24'b0, bus.drop_count}, 32'd254);
      if (i == 254) check_vec("drop_cnt_255", {24'b0, bus.drop_count}, 32'd255);
    end
    drive(1'b0, 2'b00, 32'h0);
    check_vec("drop_no_valid", {31'b0, any_valid}, 32'h0);
    check_vec("drop_saturated", {24'b0, bus.drop_count}, 32'd255);

    // Fill all slots, then asynchronous reset between edges
    bus.out_0_ready = 1'b0;
    bus.out_1_ready = 1'b0;
    bus.out_2_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h0A0A_0A0A);
    tick();
    drive(1'b1, 2'b01, 32'h0B0B_0B0B);
    tick();
    drive(1'b1, 2'b10, 32'h0C0C_0C0C);
    tick();
    drive(1'b0, 2'b00, 32'h0);
    check_vec("fill_valid", {29'b0, bus.out_2_valid, bus.out_1_valid, bus.out_0_valid}, 32'h7);
    check_vec("fill_d1", bus.out_1_data, 32'h0B0B_0B0B);
    #2 rst = 1'b0;
    #1;
    check_vec("arst_valid", {29'b0, bus.out_2_valid, bus.out_1_valid, bus.out_0_valid}, 32'h0);
    check_vec("arst_d0", bus.out_0_data, 32'h0);
    check_vec("arst_d1", bus.out_1_data, 32'h0);
    check_vec("arst_d2", bus.out_2_data, 32'h0);
    check_vec("arst_drop", {24'b0, bus.drop_count}, 32'h0);
    check_vec("arst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    #1 rst = 1'b1;
    bus.out_0_ready = 1'b1;
    bus.out_1_ready = 1'b1;
    bus.out_2_ready = 1'b1;
    drive(1'b1, 2'b00, 32'h1234_5678);
    tick();
    drive(1'b0, 2'b00, 32'h0);
    check_vec("post_rst_v0", {31'b0, bus.out_0_valid}, 32'h1);
    check_vec("post_rst_d0", bus.out_0_data, 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_1_to_3_32_bit.md
# demux_1_to_3_32_bit

One-in, three-out 32-bit registered demultiplexer with valid/ready handshakes on every side. It routes each accepted input word to one of three output channels chosen by a 2-bit select that travels with the word. This is the distribution counterpart of the 3-to-1 word mux, used wherever the datapath fans one producer out to three consumers that may stall independently. Each output channel owns a one-entry holding register, so a stall on one channel never blocks traffic bound for another.

## Interface
Parameters:
- WIDTH, 32, data word width; all data ports use it.
- DROP_CNT_W, 8, width of the dropped-word counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word offered by the producer.
- in_sel  input  2  destination: 2'b00 to out_0, 2'b01 to out_1, 2'b10 to out_2, 2'b11 means discard.
- in_valid  input  1  in_data and in_sel are valid.
- in_ready  output  1  the block accepts the word this cycle.
- out_N_data  output  WIDTH  word held for channel N (N = 0, 1, 2).
- out_N_valid  output  1  channel N holds a word.
- out_N_ready  input  1  consumer N takes the word this cycle.
- drop_count  output  DROP_CNT_W  number of words discarded via in_sel = 2'b11; saturating.

## Operation
- Transfer rule on every interface: a word moves on a rising edge where valid and ready are both high.
- Slot N is free when out_N_valid = 0, or when out_N_valid = 1 and out_N_ready = 1 in the same cycle.
- in_ready:
  - For in_sel = 00/01/10, in_ready equals "selected slot free".
  - For in_sel = 11, in_ready = 1.
  - in_ready depends only on in_sel and the selected slot; the other slots have no effect.
- Accepting in_sel 00/01/10:
  - The selected slot loads in_data and keeps out_N_valid = 1.
  - A drain and a load of the same slot in the same cycle are legal and replace the held word.
- Accepting in_sel = 11: the word is discarded and drop_count increments. drop_count holds at its all-ones value and never wraps.
- A slot that drains without a new load clears out_N_valid. Its out_N_data keeps the last value; consumers must ignore out_N_data while out_N_valid = 0.
- A slot that is neither drained nor loaded holds its data and valid bit unchanged, with no dependency on in_valid.
- Words to the same channel leave in acceptance order. There is no ordering guarantee across channels.
- in_sel and in_data are ignored while in_valid = 0.

## Timing
- Reset (rst low, asynchronous):
  - All out_N_valid go to 0 and all out_N_data go to WORD_ZERO immediately.
  - drop_count goes to 0.
  - Held words are lost.
  - in_ready still follows its combinational rule (slots are empty, so it is 1).
- Reset release: the first transfer can occur on the first rising edge after rst goes high.
- Latency: a word accepted at edge k appears on out_N_data with out_N_valid = 1 immediately after edge k.
- Throughput: one word per cycle into any channel whose consumer holds out_N_ready high.
- Combinational paths:
  - out_N_ready and in_sel to in_ready.
  - No combinational path from input data or valid to any output.
- Simultaneous events:
  - A load to one slot and drains on the other two in the same cycle are independent and all take effect.
  - A drop and drains in the same cycle are also independent.

## Structure
- WORD_ZERO comes from the shared constants header, not a local literal.
- The channel encodings move to the shared constants header as named 2-bit constants (OUT_0, OUT_1, OUT_2, DISCARD) so the mux and this block decode identically.
- One sub-module, demux_out_slot:
  - A one-entry valid/ready holding register with inputs load, load_data, drain_ready.
  - Outputs are valid, data and free.
  - Instantiated three times.
- The top level contains the select decode, the in_ready mux and the saturating drop counter.

## Test plan
- Basic route: after reset, hold all out_N_ready = 1 and send 32'hCCCC_CCCC with in_sel = 01.
  - Required: out_1_valid = 1 with that data one edge later; out_0_valid and out_2_valid stay 0.
- Independent stall: out_2_ready = 0, send 32'hDDDD_DDDD to 10, then 32'h1111_1111 to 10, then 32'h2222_2222 to 00.
  - Required: in_ready drops for the second word only; the 00 word is accepted on the next edge.
  - Raising out_2_ready then drains DDDD_DDDD, after which 1111_1111 is accepted.
- Back-to-back: send 4 words to channel 0 on consecutive cycles with out_0_ready = 1.
  - Required: in_ready stays 1 throughout; the words appear in order, one per cycle; a drain and load occur on the same edge.
- Discard: send 300 words with in_sel = 11.
  - Required: in_ready = 1 throughout; no out_N_valid ever asserts; drop_count reads 255, saturated.
- Reset mid-operation: fill all three slots with out_N_ready = 0, then pulse rst low between edges.
  - Required: out_N_valid, out_N_data and drop_count clear immediately, before the next edge.
  - Required: a word sent after release is delivered normally.
